frodo_bank_router: RTL and testbench
====================================

// Module: frodo_bank_router
// PURPOSE
//  Memory-side responder for the four AGU address streams (channels 0..3 = A,B,C,D).
//  Decodes each {bank,row} address, arbitrates per bank and drives four single-port SRAM banks.
//  Returns read data to the requesting channel.
//  gnt[i] is the AGU add_en qualifier: a channel advances its address only when granted.
// PARAMETERS
//  ADDR_WIDTH  12  row address width; channel address is ADDR_WIDTH+2 bits, top 2 bits = bank
//  DATA_WIDTH  16  SRAM word width
// PORTS
//  clk          in   1               clock, rising edge
//  rstn         in   1               asynchronous active-low reset
//  ch_req       in   4               per-channel access request
//  ch_we        in   4               per-channel write (1) / read (0)
//  ch_addr      in   4*(ADDR_WIDTH+2) channel i at [i*(ADDR_WIDTH+2) +: ADDR_WIDTH+2]
//  ch_wdata     in   4*DATA_WIDTH    per-channel write data
//  ch_gnt       out  4               request accepted this cycle (combinational)
//  ch_rvalid    out  4               read data valid for channel i
//  ch_rdata     out  4*DATA_WIDTH    per-channel read data
//  bank_en      out  4               SRAM bank enable
//  bank_we      out  4               SRAM bank write enable
//  bank_addr    out  4*ADDR_WIDTH    SRAM row address
//  bank_wdata   out  4*DATA_WIDTH    SRAM write data
//  bank_rdata   in   4*DATA_WIDTH    SRAM read data, valid 1 cycle after bank_en&~bank_we
//  conflict_cnt out  4*16            per-bank conflict counters (AGU_CONFLICT_CNT_EN only)
// BEHAVIOUR
//  - Decode: bank = addr[ADDR_WIDTH+1:ADDR_WIDTH], row = addr[ADDR_WIDTH-1:0].
//  - Per bank, one access per cycle. Fixed priority: ch0 > ch1 > ch2 > ch3.
//  - Identical addresses do not merge; they are handled as a conflict.
//  - ch_gnt[i] = ch_req[i] & won(bank(i)). ch_gnt is asserted in the same cycle as the request.
//  - bank_en, bank_we, bank_addr and bank_wdata are driven combinationally from the winner.
//    Idle banks drive bank_en=0, bank_addr=0 and bank_wdata=0.
//  - Channels hold req, we, addr and wdata stable until granted.
//    An ungranted request has no side effect.
//  - Read latency is 2 cycles: grant at cycle t -> ch_rvalid[i]=1 with ch_rdata[i] at t+2.
//    - t+1: SRAM output.
//    - t+2: registered result, routed by a per-channel bank-index pipeline.
//  - Writes: committed at the grant edge; no rvalid is produced.
//  - One read per channel per cycle gives a fully pipelined throughput of 1 read/cycle/channel.
//  - ch_rdata holds its last value when ch_rvalid=0.
//  - Reset (async, any time): ch_rvalid=0, ch_rdata=0, the rvalid/bank-index pipeline is cleared
//    and conflict_cnt=0. Reads in flight are dropped and never return.
//  - ch_gnt and bank_* are combinational. Under rstn=0 they are forced to 0.
// CONFIGURATION
//  AGU_CONFLICT_CNT_EN defined:
//    - conflict_cnt[b] increments by 1 in every cycle in which bank b has at least 2 requesters.
//    - The counter saturates at 16'hFFFF.
//  Macro undefined: no counter logic is built and conflict_cnt is tied to 0.
//  Grant behaviour is identical in both builds.
// STRUCTURE
//  Package frodo_mem_pkg holds:
//   - NUM_CH=4, NUM_BANK=4, RD_LAT=2, CNT_W=16
//   - typedefs bank_idx_t (2b) and ch_idx_t (2b)
//   - bank-decode function
//  Sub-module frodo_bank_arb: one 4-way fixed-priority arbiter per bank, instantiated 4 times.
//   - Inputs: request vector of channels targeting that bank.
//   - Outputs: one-hot winner, winner index and a conflict flag.
// TESTING
//  1. Reset: rstn=0 mid-read -> all outputs 0. The in-flight read never raises ch_rvalid after release.
//  2. No conflict: ch0 reads 0x0005 and ch1 reads 0x1005 in the same cycle.
//     -> both granted; rvalid on both at t+2 with the bank0 row5 and bank1 row5 data.
//  3. Conflict: ch1 and ch3 both read bank2 row7.
//     -> cycle t: gnt=4'b0010; cycle t+1: gnt=4'b1000.
//     -> ch3 rvalid at t+3. With AGU_CONFLICT_CNT_EN, conflict_cnt[2]=1.
//  4. Write then read: ch3 writes 0xBEEF to 0x3010 at t; ch0 reads 0x3010 at t+1.
//     -> ch0 rdata=0xBEEF at t+3.
//  5. Streaming: ch0 reads rows 0..15 of bank0 back-to-back -> 16 consecutive rvalid cycles, data in order.
//  6. Full contention: all 4 channels target bank1 for 3 cycles.
//     -> grants go to ch0 every cycle and ch1..3 starve.
//     -> conflict_cnt[1]=3; saturation is forced at 16'hFFFF and holds there.

Source files
------------

// File: rtl/frodo_bank_router_pkg.sv
// Shared sizing, index types and address decode for the AGU memory-side bank router.
package frodo_mem_pkg;

    localparam int NUM_CH   = 4;
    localparam int NUM_BANK = 4;
    localparam int RD_LAT   = 2;
    localparam int CNT_W    = 16;

    typedef logic [1:0] bank_idx_t;
    typedef logic [1:0] ch_idx_t;

    // Read tag carried from grant to the SRAM output cycle.
    typedef struct packed {
        logic      vld;
        bank_idx_t bidx;
    } rd_tag_t;

    // Bank select is the two bits directly above the row field.
    function automatic bank_idx_t bank_of(input logic [31:0] addr, input int row_w);
        return bank_idx_t'(addr >> row_w);
    endfunction

endpackage

// File: rtl/frodo_bank_router_if.sv
// Channel-side and SRAM-side signal bundle of the bank router; the router takes the slave view.
interface frodo_bank_router_if
    import frodo_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
);
    localparam int CH_AW = ADDR_WIDTH + 2;

    logic [NUM_CH-1:0]              ch_req;
    logic [NUM_CH-1:0]              ch_we;
    logic [NUM_CH*CH_AW-1:0]        ch_addr;
    logic [NUM_CH*DATA_WIDTH-1:0]   ch_wdata;
    logic [NUM_CH-1:0]              ch_gnt;
    logic [NUM_CH-1:0]              ch_rvalid;
    logic [NUM_CH*DATA_WIDTH-1:0]   ch_rdata;
    logic [NUM_BANK-1:0]            bank_en;
    logic [NUM_BANK-1:0]            bank_we;
    logic [NUM_BANK*ADDR_WIDTH-1:0] bank_addr;
    logic [NUM_BANK*DATA_WIDTH-1:0] bank_wdata;
    logic [NUM_BANK*DATA_WIDTH-1:0] bank_rdata;
    logic [NUM_BANK*CNT_W-1:0]      conflict_cnt;

    modport master (
        output ch_req, ch_we, ch_addr, ch_wdata, bank_rdata,
        input  ch_gnt, ch_rvalid, ch_rdata, bank_en, bank_we, bank_addr, bank_wdata, conflict_cnt
    );

    modport slave (
        input  ch_req, ch_we, ch_addr, ch_wdata, bank_rdata,
        output ch_gnt, ch_rvalid, ch_rdata, bank_en, bank_we, bank_addr, bank_wdata, conflict_cnt
    );

endinterface

// File: rtl/frodo_bank_router_arb.sv
// Per-bank 4-way fixed-priority arbiter (channel 0 highest) with a multi-requester flag.
module frodo_bank_arb
    import frodo_mem_pkg::*;
(
    input  logic [NUM_CH-1:0] req_i,
    output logic [NUM_CH-1:0] gnt_o,
    output ch_idx_t           win_o,
    output logic              conflict_o
);

    // Scan from lowest priority upward so the last hit is the highest-priority requester.
    always_comb begin
        gnt_o = '0;
        win_o = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
                win_o    = ch_idx_t'(i);
            end
        end
    end

    assign conflict_o = ($countones(req_i) > 1);

endmodule

// File: rtl/frodo_bank_router.sv
// Routes four AGU channels onto four single-port SRAM banks with 2-cycle read return.
// Optional build macro AGU_CONFLICT_CNT_EN adds saturating per-bank conflict counters.
module frodo_bank_router
    import frodo_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
) (
    input  logic               clk,
    input  logic               rstn,
    frodo_bank_router_if.slave bus
);

    localparam int CH_AW = ADDR_WIDTH + 2;

    logic [NUM_CH-1:0][CH_AW-1:0]           ch_addr_a;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0]      ch_wdata_a;
    logic [NUM_BANK-1:0][DATA_WIDTH-1:0]    bank_rdata_a;
    bank_idx_t [NUM_CH-1:0]                 ch_bank;
    logic [NUM_CH-1:0][ADDR_WIDTH-1:0]      ch_row;

    logic [NUM_BANK-1:0][NUM_CH-1:0]        bank_req;
    logic [NUM_BANK-1:0][NUM_CH-1:0]        bank_gnt;
    ch_idx_t [NUM_BANK-1:0]                 bank_win;
    logic [NUM_BANK-1:0]                    bank_conf;

    logic [NUM_CH-1:0]                      gnt_raw;
    logic [NUM_CH-1:0]                      gnt_c;
    logic [NUM_BANK-1:0]                    en_c;
    logic [NUM_BANK-1:0]                    we_c;
    logic [NUM_BANK-1:0][ADDR_WIDTH-1:0]    baddr_c;
    logic [NUM_BANK-1:0][DATA_WIDTH-1:0]    bwdata_c;

    rd_tag_t [NUM_CH-1:0]                   rd_p0_d;
    rd_tag_t [NUM_CH-1:0]                   rd_p0_q;
    logic [NUM_CH-1:0]                      rvalid_p1_d;
    logic [NUM_CH-1:0]                      rvalid_p1_q;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0]      rdata_p1_d;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0]      rdata_p1_q;

    assign ch_addr_a    = bus.ch_addr;
    assign ch_wdata_a   = bus.ch_wdata;
    assign bank_rdata_a = bus.bank_rdata;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_bank[i] = bank_of(32'(ch_addr_a[i]), ADDR_WIDTH);
            ch_row[i]  = ch_addr_a[i][ADDR_WIDTH-1:0];
        end
    end

    always_comb begin
        bank_req = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                bank_req[b][i] = bus.ch_req[i] && (ch_bank[i] == bank_idx_t'(b));
            end
        end
    end

    for (genvar g = 0; g < NUM_BANK; g++) begin : g_arb
        frodo_bank_arb u_arb (
            .req_i      (bank_req[g]),
            .gnt_o      (bank_gnt[g]),
            .win_o      (bank_win[g]),
            .conflict_o (bank_conf[g])
        );
    end

    // Visible grant and SRAM controls are forced low while reset is held.
    always_comb begin
        gnt_raw  = '0;
        gnt_c    = '0;
        en_c     = '0;
        we_c     = '0;
        baddr_c  = '0;
        bwdata_c = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            gnt_raw = gnt_raw | bank_gnt[b];
        end
        if (rstn) begin
            gnt_c = gnt_raw;
            for (int b = 0; b < NUM_BANK; b++) begin
                if (|bank_req[b]) begin
                    en_c[b]     = 1'b1;
                    we_c[b]     = bus.ch_we[bank_win[b]];
                    baddr_c[b]  = ch_row[bank_win[b]];
                    bwdata_c[b] = ch_wdata_a[bank_win[b]];
                end
            end
        end
    end

    assign bus.ch_gnt     = gnt_c;
    assign bus.bank_en    = en_c;
    assign bus.bank_we    = we_c;
    assign bus.bank_addr  = baddr_c;
    assign bus.bank_wdata = bwdata_c;

    // p0: read tag captured at the grant edge; p1: SRAM word registered and steered per channel.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            rd_p0_d[i].vld  = gnt_raw[i] & ~bus.ch_we[i];
            rd_p0_d[i].bidx = ch_bank[i];
            rvalid_p1_d[i]  = rd_p0_q[i].vld;
            rdata_p1_d[i]   = rd_p0_q[i].vld ? bank_rdata_a[rd_p0_q[i].bidx] : rdata_p1_q[i];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_p0_q     <= '0;
            rvalid_p1_q <= '0;
            rdata_p1_q  <= '0;
        end else begin
            rd_p0_q     <= rd_p0_d;
            rvalid_p1_q <= rvalid_p1_d;
            rdata_p1_q  <= rdata_p1_d;
        end
    end

    assign bus.ch_rvalid = rvalid_p1_q;
    assign bus.ch_rdata  = rdata_p1_q;

`ifdef AGU_CONFLICT_CNT_EN
    logic [NUM_BANK-1:0][CNT_W-1:0] cnt_d;
    logic [NUM_BANK-1:0][CNT_W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        for (int b = 0; b < NUM_BANK; b++) begin
            if (bank_conf[b] && (cnt_q[b] != {CNT_W{1'b1}})) begin
                cnt_d[b] = cnt_q[b] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.conflict_cnt = cnt_q;
`else
    logic unused_conf;
    assign unused_conf      = |bank_conf;
    assign bus.conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_frodo_bank_router.sv
// Directed bench for frodo_bank_router with a behavioural 1-cycle-latency SRAM per bank.
module tb_frodo_bank_router;

    logic clk;
    logic rstn;
    int   total = 0;
    int   bad   = 0;

    frodo_bank_router_if #(.ADDR_WIDTH(12), .DATA_WIDTH(16)) bus ();

    frodo_bank_router #(.ADDR_WIDTH(12), .DATA_WIDTH(16)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: rows hold {2'b10, bank, row} unless overwritten (one overlay entry per bank).
    logic [3:0][15:0] sram_q;
    logic [3:0]       ov_vld;
    logic [3:0][11:0] ov_row;
    logic [3:0][15:0] ov_dat;

    function automatic logic [15:0] pat(input int b, input logic [11:0] r);
        return {2'b10, 2'(b), r};
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ov_vld <= '0;
            ov_row <= '0;
            ov_dat <= '0;
            sram_q <= '0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (bus.bank_en[b]) begin
                    if (bus.bank_we[b]) begin
                        ov_vld[b] <= 1'b1;
                        ov_row[b] <= bus.bank_addr[b*12 +: 12];
                        ov_dat[b] <= bus.bank_wdata[b*16 +: 16];
                    end else if (ov_vld[b] && ov_row[b] == bus.bank_addr[b*12 +: 12]) begin
                        sram_q[b] <= ov_dat[b];
                    end else begin
                        sram_q[b] <= pat(b, bus.bank_addr[b*12 +: 12]);
                    end
                end
            end
        end
    end

    assign bus.bank_rdata = sram_q;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.ch_req   = '0;
        bus.ch_we    = '0;
        bus.ch_addr  = '0;
        bus.ch_wdata = '0;
    endtask

    task automatic set_rd(input int ch, input logic [13:0] a);
        bus.ch_req[ch]        = 1'b1;
        bus.ch_we[ch]         = 1'b0;
        bus.ch_addr[ch*14 +: 14] = a;
    endtask

    task automatic set_wr(input int ch, input logic [13:0] a, input logic [15:0] d);
        bus.ch_req[ch]            = 1'b1;
        bus.ch_we[ch]             = 1'b1;
        bus.ch_addr[ch*14 +: 14]  = a;
        bus.ch_wdata[ch*16 +: 16] = d;
    endtask

    logic [15:0] exp_cnt3;
    logic [15:0] exp_cnt1;

    initial begin
`ifdef AGU_CONFLICT_CNT_EN
        exp_cnt3 = 16'd3;
        exp_cnt1 = 16'd1;
`else
        exp_cnt3 = 16'd0;
        exp_cnt1 = 16'd0;
`endif
        rstn = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        bus.ch_req = 4'hF;
        @(negedge clk);
        check_eq("rst_gnt", 64'(bus.ch_gnt), 64'h0);
        check_eq("rst_bank_en", 64'(bus.bank_en), 64'h0);
        check_eq("rst_rvalid", 64'(bus.ch_rvalid), 64'h0);
        check_eq("rst_rdata", bus.ch_rdata, 64'h0);
        check_eq("rst_cnt", bus.conflict_cnt, 64'h0);
        idle();
        #1;
        rstn = 1'b1;

        // Two channels, two banks, same cycle.
        tick();
        set_rd(0, 14'h0005);
        set_rd(1, 14'h1005);
        @(negedge clk);
        check_eq("nc_gnt", 64'(bus.ch_gnt), 64'h3);
        check_eq("nc_bank_en", 64'(bus.bank_en), 64'h3);
        check_eq("nc_addr1", 64'(bus.bank_addr[12 +: 12]), 64'h005);
        tick();
        idle();
        @(negedge clk);
        check_eq("nc_rv_t1", 64'(bus.ch_rvalid), 64'h0);
        tick();
        @(negedge clk);
        check_eq("nc_rv_t2", 64'(bus.ch_rvalid), 64'h3);
        check_eq("nc_rd0", 64'(bus.ch_rdata[0 +: 16]), 64'h8005);
        check_eq("nc_rd1", 64'(bus.ch_rdata[16 +: 16]), 64'h9005);
        tick();
        @(negedge clk);
        check_eq("nc_rv_t3", 64'(bus.ch_rvalid), 64'h0);
        check_eq("nc_hold0", 64'(bus.ch_rdata[0 +: 16]), 64'h8005);

        // Reset while a read is in flight.
        tick();
        set_rd(0, 14'h0009);
        @(negedge clk);
        check_eq("mr_gnt", 64'(bus.ch_gnt), 64'h1);
        tick();
        idle();
        #2;
        rstn = 1'b0;
        bus.ch_req = 4'b0001;
        #1;
        check_eq("mr_rvalid", 64'(bus.ch_rvalid), 64'h0);
        check_eq("mr_rdata", bus.ch_rdata, 64'h0);
        check_eq("mr_gnt_forced", 64'(bus.ch_gnt), 64'h0);
        check_eq("mr_en_forced", 64'(bus.bank_en), 64'h0);
        idle();
        @(negedge clk);
        #1;
        rstn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            @(negedge clk);
            check_eq("mr_no_return", 64'(bus.ch_rvalid), 64'h0);
        end

        // ch1 and ch3 collide on bank2 row7.
        tick();
        set_rd(1, 14'h2007);
        set_rd(3, 14'h2007);
        @(negedge clk);
        check_eq("cf_gnt_t0", 64'(bus.ch_gnt), 64'h2);
        check_eq("cf_addr2", 64'(bus.bank_addr[24 +: 12]), 64'h007);
        tick();
        bus.ch_req[1] = 1'b0;
        @(negedge clk);
        check_eq("cf_gnt_t1", 64'(bus.ch_gnt), 64'h8);
        tick();
        idle();
        @(negedge clk);
        check_eq("cf_rv_t2", 64'(bus.ch_rvalid), 64'h2);
        check_eq("cf_rd1", 64'(bus.ch_rdata[16 +: 16]), 64'hA007);
        tick();
        @(negedge clk);
        check_eq("cf_rv_t3", 64'(bus.ch_rvalid), 64'h8);
        check_eq("cf_rd3", 64'(bus.ch_rdata[48 +: 16]), 64'hA007);
        check_eq("cf_cnt2", 64'(bus.conflict_cnt[32 +: 16]), 64'(exp_cnt1));
        tick();
        @(negedge clk);
        check_eq("cf_rv_t4", 64'(bus.ch_rvalid), 64'h0);

        // Write on ch3, read back on ch0 one cycle later.
        tick();
        set_wr(3, 14'h3010, 16'hBEEF);
        @(negedge clk);
        check_eq("wr_gnt", 64'(bus.ch_gnt), 64'h8);
        check_eq("wr_bank_we", 64'(bus.bank_we), 64'h8);
        check_eq("wr_wdata3", 64'(bus.bank_wdata[48 +: 16]), 64'hBEEF);
        tick();
        idle();
        set_rd(0, 14'h3010);
        @(negedge clk);
        check_eq("wr_rd_gnt", 64'(bus.ch_gnt), 64'h1);
        tick();
        idle();
        @(negedge clk);
        check_eq("wr_rv_t2", 64'(bus.ch_rvalid), 64'h0);
        tick();
        @(negedge clk);
        check_eq("wr_rv_t3", 64'(bus.ch_rvalid), 64'h1);
        check_eq("wr_rd0", 64'(bus.ch_rdata[0 +: 16]), 64'hBEEF);
        tick();
        @(negedge clk);
        check_eq("wr_rv_t4", 64'(bus.ch_rvalid), 64'h0);

        // ch0 streams rows 0..15 of bank0.
        for (int c = 0; c < 19; c++) begin
            tick();
            idle();
            if (c < 16) set_rd(0, 14'(c));
            @(negedge clk);
            if (c < 16) check_eq("st_gnt", 64'(bus.ch_gnt[0]), 64'h1);
            if (c >= 2 && c < 18) begin
                check_eq("st_rv", 64'(bus.ch_rvalid[0]), 64'h1);
                check_eq("st_rd", 64'(bus.ch_rdata[0 +: 16]), 64'(16'h8000 + 16'(c - 2)));
            end else begin
                check_eq("st_rv_idle", 64'(bus.ch_rvalid[0]), 64'h0);
            end
        end

        // All four channels on bank1 for three cycles.
        for (int c = 0; c < 3; c++) begin
            tick();
            idle();
            set_rd(0, 14'h1000 + 14'(c));
            set_rd(1, 14'h1100);
            set_rd(2, 14'h1200);
            set_rd(3, 14'h1300);
            @(negedge clk);
            check_eq("fc_gnt", 64'(bus.ch_gnt), 64'h1);
            check_eq("fc_addr1", 64'(bus.bank_addr[12 +: 12]), 64'(c));
        end
        tick();
        idle();
        @(negedge clk);
        check_eq("fc_cnt1", 64'(bus.conflict_cnt[16 +: 16]), 64'(exp_cnt3));
        check_eq("fc_cnt2_kept", 64'(bus.conflict_cnt[32 +: 16]), 64'(exp_cnt1));

`ifdef AGU_CONFLICT_CNT_EN
        tick();
        set_rd(0, 14'h1000);
        set_rd(1, 14'h1100);
        set_rd(2, 14'h1200);
        set_rd(3, 14'h1300);
        repeat (65536) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("sat_cnt1", 64'(bus.conflict_cnt[16 +: 16]), 64'hFFFF);
        tick();
        tick();
        @(negedge clk);
        check_eq("sat_hold", 64'(bus.conflict_cnt[16 +: 16]), 64'hFFFF);
        idle();
`endif

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
